wordcell_access_ctrl: RTL and testbench
=======================================

# wordcell_access_ctrl

Synchronous initiator driving an array of `Wordcell` latch words through their `op` / `sel_x` / `in_bus` / `out_bus` interface. It converts a valid/ready request port into correctly sequenced array cycles:
- writes are setup → write → hold;
- reads are select → sample.

It returns one response per request, and sits between a processor-style master and the NAND-latch word array.

## Interface
Parameters:
- `ADDR_W`, default 2: word address width; the array has `NUM_WORDS = 2**ADDR_W` words (derived, not overridable).
- `WR_CYCLES`, default 1: cycles `op`=1 is held with the word selected; must be ≥1.
- `RD_CYCLES`, default 1: cycles the word is selected with `op`=0 before `arr_rdata` is sampled; must be ≥1.

Ports:
- `clk` input 1: single clock, all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: target word.
- `req_wdata` input 8: write data.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: master accepts the response.
- `rsp_rdata` output 8: read data; for writes, the written data, or the readback value if verify is enabled.
- `rsp_err` output 1: write-verify mismatch; constant 0 without verify.
- `op` output 1: array operation, 1 = write, 0 = read.
- `sel_x` output NUM_WORDS: one-hot word select; all zero when idle.
- `in_bus` output 8: array write data.
- `arr_rdata` input 8: OR of all words' `out_bus` gated by their select; valid while a word is selected with `op`=0.

## Operation
- States: IDLE, SETUP, WRITE, HOLD, READ, VERIFY (only with the macro), RESP.
- `req_ready` = (state == IDLE). A request is accepted on a rising edge with `req_valid && req_ready`; `req_addr`, `req_we` and `req_wdata` are registered at that edge.
- **IDLE:** `op`=0, `sel_x`=0. On accept, go to SETUP if `req_we`=1, else to READ.
- **SETUP** (1 cycle): `in_bus` = wdata, `sel_x`=0, `op`=0. Data is stable before the latch opens.
- **WRITE** (WR_CYCLES cycles): `sel_x` = onehot(addr), `op`=1, `in_bus` held.
- **HOLD** (1 cycle): `op`=0, `sel_x`=0, `in_bus` still held. Exit to RESP, or to VERIFY when verify is enabled.
- **READ** (RD_CYCLES cycles): `sel_x` = onehot(addr), `op`=0, `in_bus`=0. `arr_rdata` is captured into `rsp_rdata` on the edge leaving READ. Go to RESP.
- **RESP:** `rsp_valid`=1, `sel_x`=0, `op`=0. `rsp_rdata` and `rsp_err` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `op`=1 is never asserted while `sel_x`=0, and `sel_x` never has more than one bit set.
- `in_bus` changes only in IDLE/SETUP entry, never while `op`=1 or during HOLD.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `op`=0, `sel_x`=0, `in_bus`=0.
- Requests presented while `rst_n` is low are ignored.
- Write latency: `rsp_valid` rises WR_CYCLES+2 cycles after the accept edge; with verify, WR_CYCLES+2+RD_CYCLES.
- Read latency: `rsp_valid` rises RD_CYCLES cycles after the accept edge.
- Throughput: the next accept is possible on the edge after the response handshake, giving at least one idle cycle between requests.
- `rsp_ready` held high in RESP: handshake on the first RESP cycle edge. `rsp_ready` low: RESP holds indefinitely.
- Reset mid-operation: `op` and `sel_x` drop to 0 immediately (asynchronously). The in-flight request is dropped with no response, and the target word content is undefined if reset hits during WRITE.
- Counters are sized to max(WR_CYCLES, RD_CYCLES) and reload on each state entry.

## Configuration
- Macro `WORDCELL_WRITE_VERIFY_EN`.
- **Defined:**
  - HOLD proceeds to VERIFY, which drives the same pattern as READ for RD_CYCLES cycles.
  - `arr_rdata` is captured into `rsp_rdata`.
  - `rsp_err` = (captured != written data).
- **Undefined:**
  - No VERIFY state.
  - The write response carries `rsp_rdata` = written data and `rsp_err`=0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WRITE → `op`, `sel_x` go to 0 without a clock edge. After release, `req_ready`=1 and `rsp_valid`=0.
- **Write/read:** write addr 2 data 0x55, then read addr 2 → read `rsp_rdata`=0x55.
  - Write: `sel_x`=4'b0100 with `op`=1 for exactly WR_CYCLES cycles, `in_bus`=0x55 from SETUP through HOLD.
  - Read latency: RD_CYCLES.
- **Overwrite:** write addr 2 data 0xCC, then read addr 2 → 0xCC. Read addr 1 (never written after reset) → model value, with `sel_x`=4'b0010 only.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stable, `req_ready`=0, no array activity. Then `rsp_ready`=1 → IDLE the next cycle.
- **Protocol checker (all tests):**
  - never `op`=1 with `sel_x`=0;
  - `$onehot0(sel_x)`;
  - `in_bus` stable whenever `op`=1 or in HOLD.
- **Verify:** with `WORDCELL_WRITE_VERIFY_EN`, the bench model forces `arr_rdata`=0x54 for a write of 0x55 → `rsp_err`=1, `rsp_rdata`=0x54. A matching readback gives `rsp_err`=0.

Source files
------------

// File: rtl/wordcell_access_ctrl.sv
// rtl/wordcell_access_ctrl.sv - valid/ready request port to Wordcell latch-array cycle sequencer
// Optional readback check after every write: define WORDCELL_WRITE_VERIFY_EN.
module wordcell_access_ctrl #(
  parameter int ADDR_W    = 2,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [7:0]             req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic                   op,
  output logic [2**ADDR_W-1:0]   sel_x,
  output logic [7:0]             in_bus,
  input  logic [7:0]             arr_rdata
);

  localparam int NUM_WORDS = 2 ** ADDR_W;
  localparam int MAX_CYC   = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_HOLD,
    S_READ,
`ifdef WORDCELL_WRITE_VERIFY_EN
    S_VERIFY,
`endif
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         in_bus_q, in_bus_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [NUM_WORDS-1:0] sel_onehot;

  assign sel_onehot = NUM_WORDS'(1) << addr_q;

  // op/sel_x decode straight from state so an async reset drops them at once
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    in_bus_d  = in_bus_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    op        = 1'b0;
    sel_x     = '0;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          if (req_we) begin
            in_bus_d = req_wdata;
            state_d  = S_SETUP;
          end else begin
            cnt_d   = RD_LOAD;
            state_d = S_READ;
          end
        end
      end
      S_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        op    = 1'b1;
        sel_x = sel_onehot;
        if (cnt_q == '0) state_d = S_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_HOLD: begin
`ifdef WORDCELL_WRITE_VERIFY_EN
        cnt_d   = RD_LOAD;
        state_d = S_VERIFY;
`else
        rdata_d = in_bus_q;
        err_d   = 1'b0;
        state_d = S_RESP;
`endif
      end
      S_READ: begin
        sel_x = sel_onehot;
        if (cnt_q == '0) begin
          rdata_d = arr_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef WORDCELL_WRITE_VERIFY_EN
      S_VERIFY: begin
        sel_x = sel_onehot;
        if (cnt_q == '0) begin
          rdata_d = arr_rdata;
          err_d   = (arr_rdata != in_bus_q);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          in_bus_d = 8'h00;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      in_bus_q <= 8'h00;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      in_bus_q <= in_bus_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign in_bus    = in_bus_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_wordcell_access_ctrl.sv
// tb/tb_wordcell_access_ctrl.sv - randomized self-checking bench for wordcell_access_ctrl
// Contains a latch-array model and a word-level expected-memory reference.
module tb_wordcell_access_ctrl;
  localparam int WR = 3;
  localparam int RD = 2;
`ifdef WORDCELL_WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       op;
  logic [3:0] sel_x;
  logic [7:0] in_bus;
  logic [7:0] arr_rdata;

  wordcell_access_ctrl #(.ADDR_W(2), .WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .op(op), .sel_x(sel_x), .in_bus(in_bus), .arr_rdata(arr_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wordcell array model: transparent latches, gated-OR readout
  logic [7:0] mem [4];
  logic [7:0] init_val [4];
  logic [7:0] ref_mem [4];
  logic       mem_loaded = 1'b0;
  logic       force_bad = 1'b0;
  logic [7:0] arr_calc;

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4; i++) mem[i] = init_val[i];
      mem_loaded = 1'b1;
    end else if (op) begin
      for (int i = 0; i < 4; i++) if (sel_x[i]) mem[i] = in_bus;
    end
  end

  always_comb begin
    arr_calc = 8'h00;
    for (int i = 0; i < 4; i++) if (sel_x[i] && !op && mem_loaded) arr_calc = arr_calc | mem[i];
  end
  assign arr_rdata = (force_bad && sel_x != 4'b0 && !op) ? 8'h54 : arr_calc;

  // Protocol monitor plus per-transaction activity capture
  int         op_cycles, sel_cycles;
  logic [3:0] op_sel, rd_sel;
  logic [7:0] op_in;
  logic       prev_op = 1'b0;
  logic [7:0] prev_in = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_op = 1'b0;
    end else begin
      check("op_without_sel", 32'(op && sel_x == 4'b0), 32'd0);
      check("sel_onehot0", 32'($onehot0(sel_x)), 32'd1);
      if (prev_op) check("in_bus_stable", 32'(in_bus), 32'(prev_in));
      if (op) begin
        op_cycles++;
        op_sel = sel_x;
        op_in  = in_bus;
      end
      if (!op && sel_x != 4'b0) begin
        sel_cycles++;
        rd_sel = sel_x;
      end
      prev_op = op;
      prev_in = in_bus;
    end
  end

  task automatic do_txn(input bit we, input logic [1:0] a, input logic [7:0] d, input int delay);
    int         lat, exp_lat;
    logic [7:0] exp_data;
    logic       exp_err;
    if (we) begin
      exp_lat  = WR + 2 + (VERIFY ? RD : 0);
      exp_data = (VERIFY && force_bad) ? 8'h54 : d;
      exp_err  = VERIFY && force_bad;
      ref_mem[a] = d;
    end else begin
      exp_lat  = RD;
      exp_data = ref_mem[a];
      exp_err  = 1'b0;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    op_cycles = 0; sel_cycles = 0; op_sel = 4'b0; rd_sel = 4'b0; op_in = 8'h00;
    rsp_ready = (delay == 0);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check(we ? "wr_latency" : "rd_latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_idle_array", 32'({op, sel_x}), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rsp_ready", 32'(req_ready), 32'd1);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    if (we) begin
      check("wr_op_cycles", 32'(op_cycles), 32'(WR));
      check("wr_sel", 32'(op_sel), 32'(4'b0001 << a));
      check("wr_in_bus", 32'(op_in), 32'(d));
      check("wr_verify_sel_cycles", 32'(sel_cycles), 32'(VERIFY ? RD : 0));
    end else begin
      check("rd_op_cycles", 32'(op_cycles), 32'd0);
      check("rd_sel_cycles", 32'(sel_cycles), 32'(RD));
      check("rd_sel", 32'(rd_sel), 32'(4'b0001 << a));
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 4; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_op_sel", 32'({op, sel_x}), 32'd0);
    check("rst_in_bus", 32'(in_bus), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b1, 2'd2, 8'h55, 0);
    do_txn(1'b0, 2'd2, 8'h00, 0);
    do_txn(1'b1, 2'd2, 8'hCC, 0);
    do_txn(1'b0, 2'd2, 8'h00, 0);
    do_txn(1'b0, 2'd1, 8'h00, 0);
    do_txn(1'b0, 2'd2, 8'h00, 5);
    do_txn(1'b1, 2'd0, 8'hA3, 5);

    if (VERIFY) begin
      force_bad = 1'b1;
      do_txn(1'b1, 2'd2, 8'h55, 0);
      force_bad = 1'b0;
      do_txn(1'b1, 2'd2, 8'h55, 0);
    end

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset landing in the middle of a write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd3; req_wdata = 8'h9E;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!op && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("midwr_op_seen", 32'(op), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_op", 32'(op), 32'd0);
    check("async_rst_sel", 32'(sel_x), 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ignores_req", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_sel", 32'({op, sel_x}), 32'd0);

    do_txn(1'b1, 2'd3, 8'h3C, 0);
    do_txn(1'b0, 2'd3, 8'h00, 0);
    do_txn(1'b0, 2'd2, 8'h00, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
